hdlc_rx_deframer: RTL

Bit-serial HDLC receive deframer; the receive-side counterpart of the transmit framer on the Econet link. It samples the line once per `netclk`, hunts for 0x7E flags and deletes stuffed zeros. It checks the CRC-16/CCITT FCS and delivers payload bytes (FCS stripped) over a valid/ack handshake. Frame status is reported to the packet buffer logic.

---
 rtl/hdlc_rx_deframer_pkg.sv | 23 ++
 rtl/hdlc_rx_deframer_if.sv | 24 ++
 rtl/hdlc_rx_deframer_crc16.sv | 35 +++
 rtl/hdlc_rx_deframer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_rx_deframer_pkg.sv
// rtl/hdlc_rx_deframer_pkg.sv - shared HDLC constants, error codes and receiver states
package hdlc_pkg;

    localparam logic [7:0]  HDLC_FLAG   = 8'h7E;
    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC_RESIDUE = 16'h1D0F;

    typedef enum logic [2:0] {
        ERR_OK      = 3'd0,
        ERR_CRC     = 3'd1,
        ERR_ABORT   = 3'd2,
        ERR_ALIGN   = 3'd3,
        ERR_RUNT    = 3'd4,
        ERR_OVERRUN = 3'd5
    } hdlc_err_e;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_FLAG  = 2'd1,
        ST_FRAME = 2'd2
    } hdlc_state_e;

endpackage

// File: rtl/hdlc_rx_deframer_if.sv
// rtl/hdlc_rx_deframer_if.sv - payload byte handshake and frame status bundle
// master (deframer): drives data_out, data_valid, frame_end, frame_good, err_code; receives data_ack
// slave (consumer):  the reverse
interface hdlc_rx_deframer_if;
    import hdlc_pkg::*;

    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ack;
    logic       frame_end;
    logic       frame_good;
    hdlc_err_e  err_code;

    modport master (
        output data_out, data_valid, frame_end, frame_good, err_code,
        input  data_ack
    );

    modport slave (
        input  data_out, data_valid, frame_end, frame_good, err_code,
        output data_ack
    );

endinterface

// File: rtl/hdlc_rx_deframer_crc16.sv
// rtl/hdlc_rx_deframer_crc16.sv - bit-serial CRC-16/CCITT (x^16+x^12+x^5+1), shift-left
// Ports: clk, reset (async, active-high), en (consume bit_in), init (restart from CRC_INIT),
//        bit_in (serial bit), crc (current register). init with en folds bit_in into a fresh CRC.
module hdlc_crc16
    import hdlc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        init,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] base;
    logic [15:0] crc_next;
    logic        fb;

    always_comb begin
        base     = init ? CRC_INIT : crc;
        fb       = bit_in ^ base[15];
        crc_next = {base[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc_next;
        end else if (init) begin
            crc <= CRC_INIT;
        end
    end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// rtl/hdlc_rx_deframer.sv - bit-serial HDLC receive deframer with zero deletion and FCS check
// Ports: netclk (line clock), reset (async, active-high), rxdata (serial line, LSB-first),
//        rx (hdlc_rx_deframer_if.master: payload handshake and frame status),
//        in_frame (state is FRAME), stat_good/stat_crc/stat_abort (frame counters).
// Build option: HDLC_RX_STATS_EN builds the saturating counters; otherwise they read 0.
module hdlc_rx_deframer
    import hdlc_pkg::*;
#(
    parameter int MIN_BYTES = 3
) (
    input  logic                netclk,
    input  logic                reset,
    input  logic                rxdata,
    hdlc_rx_deframer_if.master  rx,
    output logic                in_frame,
    output logic [15:0]         stat_good,
    output logic [15:0]         stat_crc,
    output logic [15:0]         stat_abort
);

    localparam logic [7:0] MIN_BYTE_CNT = 8'(MIN_BYTES);

    hdlc_state_e state, state_next;
    logic [2:0]  ones_cnt;
    logic [6:0]  dl_bits;
    logic [2:0]  dl_cnt;
    logic [6:0]  shreg;
    logic [2:0]  bit_idx;
    logic [7:0]  byte_cnt;
    logic [7:0]  hold0, hold1;
    logic [1:0]  hold_cnt;
    logic [15:0] crc;

    logic        is_stuff, is_flag, is_abort, push, exit_v, exit_bit;
    logic        enter, frame_bit, byte_done, busy, overrun, close;
    logic [2:0]  eff_idx;
    logic [7:0]  new_byte;
    logic        fe_next, good_next;
    hdlc_err_e   err_next, close_err;

    always_comb begin
        state_next = state;
        fe_next    = 1'b0;
        good_next  = 1'b0;
        err_next   = ERR_OK;
        close_err  = ERR_OK;

        is_stuff = !rxdata && (ones_cnt == 3'd5);
        is_flag  = !rxdata && (ones_cnt == 3'd6);
        is_abort =  rxdata && (ones_cnt == 3'd6);
        // The sixth 1 is held in the delay line until the next bit shows
        // whether it was data (impossible after stuffing), a flag or an abort.
        push     = !is_stuff && !is_flag && !is_abort;
        exit_v   = push && (dl_cnt == 3'd7);
        exit_bit = dl_bits[6];

        enter     = exit_v && (state == ST_FLAG);
        frame_bit = exit_v && ((state == ST_FLAG) || (state == ST_FRAME));
        eff_idx   = enter ? 3'd0 : bit_idx;
        byte_done = frame_bit && (eff_idx == 3'd7);
        new_byte  = {exit_bit, shreg};
        busy      = rx.data_valid && !rx.data_ack;
        overrun   = byte_done && (hold_cnt == 2'd2) && busy;
        close     = is_flag && (state == ST_FRAME);

        if (bit_idx != 3'd0) begin
            close_err = ERR_ALIGN;
        end else if (byte_cnt < MIN_BYTE_CNT) begin
            close_err = ERR_RUNT;
        end else if (crc != CRC_RESIDUE) begin
            close_err = ERR_CRC;
        end

        if (is_abort) begin
            state_next = ST_HUNT;
        end else if (is_flag) begin
            state_next = ST_FLAG;
        end else if (overrun) begin
            state_next = ST_HUNT;
        end else if (enter) begin
            state_next = ST_FRAME;
        end

        if (close) begin
            fe_next   = 1'b1;
            err_next  = close_err;
            good_next = (close_err == ERR_OK);
        end else if (is_abort && (state == ST_FRAME)) begin
            fe_next  = 1'b1;
            err_next = ERR_ABORT;
        end else if (overrun) begin
            fe_next  = 1'b1;
            err_next = ERR_OVERRUN;
        end
    end

    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            state <= ST_HUNT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            ones_cnt      <= 3'd0;
            dl_bits       <= 7'd0;
            dl_cnt        <= 3'd0;
            shreg         <= 7'd0;
            bit_idx       <= 3'd0;
            byte_cnt      <= 8'd0;
            hold0         <= 8'd0;
            hold1         <= 8'd0;
            hold_cnt      <= 2'd0;
            rx.data_out   <= 8'h00;
            rx.data_valid <= 1'b0;
            rx.frame_end  <= 1'b0;
            rx.frame_good <= 1'b0;
            rx.err_code   <= ERR_OK;
        end else begin
            rx.frame_end  <= fe_next;
            rx.frame_good <= good_next;
            rx.err_code   <= err_next;

            if (rxdata) begin
                ones_cnt <= (ones_cnt == 3'd7) ? 3'd7 : ones_cnt + 3'd1;
            end else begin
                ones_cnt <= 3'd0;
            end

            // Flags and aborts flush the delay line so their bits never
            // reach the CRC or the byte assembler.
            if (is_flag || is_abort) begin
                dl_cnt <= 3'd0;
            end else if (push) begin
                dl_bits <= {dl_bits[5:0], rxdata};
                if (dl_cnt != 3'd7) begin
                    dl_cnt <= dl_cnt + 3'd1;
                end
            end

            if (rx.data_valid && rx.data_ack) begin
                rx.data_valid <= 1'b0;
            end

            if (frame_bit) begin
                shreg   <= {exit_bit, shreg[6:1]};
                bit_idx <= eff_idx + 3'd1;
                if (enter) begin
                    byte_cnt <= 8'd0;
                    hold_cnt <= 2'd0;
                end
                if (byte_done) begin
                    if (byte_cnt != 8'hFF) begin
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                    // Two-byte holdback: the last two bytes of a frame are
                    // the FCS and must never be presented.
                    if (hold_cnt == 2'd2) begin
                        if (!busy) begin
                            rx.data_out   <= hold0;
                            rx.data_valid <= 1'b1;
                            hold0         <= hold1;
                            hold1         <= new_byte;
                        end
                    end else if (hold_cnt == 2'd1) begin
                        hold1    <= new_byte;
                        hold_cnt <= 2'd2;
                    end else begin
                        hold0    <= new_byte;
                        hold_cnt <= 2'd1;
                    end
                end
            end
        end
    end

    hdlc_crc16 u_crc (
        .clk    (netclk),
        .reset  (reset),
        .en     (frame_bit),
        .init   (enter),
        .bit_in (exit_bit),
        .crc    (crc)
    );

    assign in_frame = (state == ST_FRAME);

`ifdef HDLC_RX_STATS_EN
    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            stat_good  <= 16'h0000;
            stat_crc   <= 16'h0000;
            stat_abort <= 16'h0000;
        end else if (rx.frame_end) begin
            if ((rx.err_code == ERR_OK) && (stat_good != 16'hFFFF)) begin
                stat_good <= stat_good + 16'h0001;
            end
            if ((rx.err_code == ERR_CRC) && (stat_crc != 16'hFFFF)) begin
                stat_crc <= stat_crc + 16'h0001;
            end
            if ((rx.err_code == ERR_ABORT) && (stat_abort != 16'hFFFF)) begin
                stat_abort <= stat_abort + 16'h0001;
            end
        end
    end
`else
    assign stat_good  = 16'h0000;
    assign stat_crc   = 16'h0000;
    assign stat_abort = 16'h0000;
`endif

endmodule
